// File: rtl/vu_level_if.sv
`default_nettype none
// ============================================================================
// Module   : vu_level_if
// Brief    : Start/window request and level/bar/peak result bundle for vu_level.
// Revision : 1.0 - initial release
// ============================================================================
interface vu_level_if #(
    parameter int W = 128
);
    logic         start;
    logic [W-1:0] window;
    logic         busy;
    logic         done;
    logic [7:0]   level;
    logic [7:0]   bar;
    logic [7:0]   peak_bar;

    modport master (
        output start, window,
        input  busy, done, level, bar, peak_bar
    );

    modport slave (
        input  start, window,
        output busy, done, level, bar, peak_bar
    );
endinterface
`default_nettype wire

// File: rtl/vu_level.sv
`default_nettype none
// ============================================================================
// Module   : vu_level
// Brief    : Scans a snapshot of N signed 8-bit samples for peak magnitude,
//            applies fall-off decay and drives an 8-segment thermometer bar.
//            Optional peak-hold marker enabled by defining VU_PEAK_HOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vu_level #(
    parameter int W     = 128,
    parameter int DECAY = 4,
    parameter int HOLD  = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    vu_level_if.slave   bus
);

    localparam int          c_N      = W / 8;
    localparam int          c_IDX_W  = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [7:0]  c_DECAY8 = 8'(DECAY);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [W-1:0]         r_win;
    logic [c_IDX_W-1:0]   r_idx;
    logic [7:0]           r_pk_s;
    logic [7:0]           r_level;
    logic [7:0]           r_bar;
    logic [7:0]           r_peak_bar;
    logic                 r_done;

    logic [7:0]           w_sample;
    logic [7:0]           w_mag;
    logic [7:0]           w_level_nx;
    logic [7:0]           w_bar_nx;
    logic [7:0]           w_peak_bar_nx;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nx = S_SCAN;
            S_SCAN:   if (r_idx == c_IDX_LAST) w_state_nx = S_UPDATE;
            S_UPDATE: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Two's-complement negate; -128 maps to 0x80 = 128 which fits unsigned 8 bits.
    assign w_sample = r_win[7:0];
    assign w_mag    = w_sample[7] ? (8'd0 - w_sample) : w_sample;

    always_comb begin
        w_level_nx = 8'd0;
        if (r_pk_s >= r_level)        w_level_nx = r_pk_s;
        else if (r_level > c_DECAY8)  w_level_nx = r_level - c_DECAY8;
        w_bar_nx = 8'd0;
        for (int k = 0; k < 8; k++) begin
            w_bar_nx[k] = (9'(w_level_nx) >= 9'(16 * (k + 1)));
        end
    end

`ifdef VU_PEAK_HOLD_EN
    localparam int c_HOLD_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    logic [7:0]          r_pkh;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [7:0]          w_pkh_nx;
    logic [c_HOLD_W-1:0] w_hold_cnt_nx;
    logic [3:0]          w_seg;

    always_comb begin
        w_pkh_nx      = r_pkh;
        w_hold_cnt_nx = r_hold_cnt;
        if (r_pk_s >= r_pkh) begin
            w_pkh_nx      = r_pk_s;
            w_hold_cnt_nx = c_HOLD_W'(HOLD);
        end else if (r_hold_cnt == '0) begin
            w_pkh_nx      = w_level_nx;
        end else begin
            w_hold_cnt_nx = r_hold_cnt - 1'b1;
        end
        w_seg         = (w_pkh_nx[7:4] > 4'd8) ? 4'd8 : w_pkh_nx[7:4];
        w_peak_bar_nx = (w_seg == 4'd0) ? 8'd0 : (8'd1 << (w_seg - 4'd1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pkh      <= 8'd0;
            r_hold_cnt <= '0;
        end else if (r_state == S_UPDATE) begin
            r_pkh      <= w_pkh_nx;
            r_hold_cnt <= w_hold_cnt_nx;
        end
    end
`else
    assign w_peak_bar_nx = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_win      <= '0;
            r_idx      <= '0;
            r_pk_s     <= 8'd0;
            r_level    <= 8'd0;
            r_bar      <= 8'd0;
            r_peak_bar <= 8'd0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_win  <= bus.window;
                        r_pk_s <= 8'd0;
                        r_idx  <= '0;
                    end
                end
                S_SCAN: begin
                    r_win  <= r_win >> 8;
                    r_pk_s <= (w_mag > r_pk_s) ? w_mag : r_pk_s;
                    r_idx  <= r_idx + 1'b1;
                end
                S_UPDATE: begin
                    r_level    <= w_level_nx;
                    r_bar      <= w_bar_nx;
                    r_peak_bar <= w_peak_bar_nx;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.level    = r_level;
    assign bus.bar      = r_bar;
    assign bus.peak_bar = r_peak_bar;

endmodule
`default_nettype wire

// File: tb/tb_vu_level.sv
`default_nettype none
// ============================================================================
// Module   : tb_vu_level
// Brief    : Directed self-checking bench for vu_level (latency, level/bar,
//            decay, start handling, mid-scan reset, optional peak hold).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vu_level;

`ifdef VU_PEAK_HOLD_EN
    localparam int c_HOLD = 2;
`else
    localparam int c_HOLD = 8;
`endif
    localparam int c_LAT = 17;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    vu_level_if #(.W(128)) vif ();

    vu_level #(.W(128), .DECAY(4), .HOLD(c_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        vif.start  = 1'b0;
        vif.window = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Returns number of edges after the start edge until done is observed.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!vif.done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pulse_start(input logic [127:0] win);
        vif.start  = 1'b1;
        vif.window = win;
        @(negedge clk);
        vif.start  = 1'b0;
        // Upstream keeps shifting; the snapshot must be unaffected.
        vif.window = {4{$urandom}};
    endtask

    task automatic run(input string tag, input logic [127:0] win,
                       input logic [7:0] e_level, input logic [7:0] e_bar,
                       input logic [7:0] e_pk);
        int lat;
        @(negedge clk);
        pulse_start(win);
        check_eq({tag, "_busy"}, 32'(vif.busy), 32'd1);
        wait_done(lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'(c_LAT));
        check_eq({tag, "_level"}, 32'(vif.level), 32'(e_level));
        check_eq({tag, "_bar"}, 32'(vif.bar), 32'(e_bar));
        check_eq({tag, "_peak"}, 32'(vif.peak_bar), 32'(e_pk));
        check_eq({tag, "_idle"}, 32'(vif.busy), 32'd0);
        @(negedge clk);
        check_eq({tag, "_done1"}, 32'(vif.done), 32'd0);
    endtask

    logic [127:0] w_tmp;
    int           lat;
    int           n_done;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        vif.start  = 1'b0;
        vif.window = '0;

        do_reset();
        check_eq("rst_busy", 32'(vif.busy), 32'd0);
        check_eq("rst_done", 32'(vif.done), 32'd0);
        check_eq("rst_level", 32'(vif.level), 32'd0);
        check_eq("rst_bar", 32'(vif.bar), 32'd0);
        check_eq("rst_peak", 32'(vif.peak_bar), 32'd0);

        run("zero", '0, 8'd0, 8'h00, 8'h00);
`ifdef VU_PEAK_HOLD_EN
        run("b5_7f", 128'h7F << 40, 8'd127, 8'h7F, 8'h40);
        run("b5_80", 128'h80 << 40, 8'd128, 8'hFF, 8'h80);
`else
        run("b5_7f", 128'h7F << 40, 8'd127, 8'h7F, 8'h00);
        run("b5_80", 128'h80 << 40, 8'd128, 8'hFF, 8'h00);
`endif

        // Decay from 48 in steps of 4.
        do_reset();
`ifdef VU_PEAK_HOLD_EN
        run("d48", 128'hD0, 8'd48, 8'h07, 8'h04);
`else
        run("d48", 128'hD0, 8'd48, 8'h07, 8'h00);
        run("d44", '0, 8'd44, 8'h03, 8'h00);
        run("d40", '0, 8'd40, 8'h03, 8'h00);
        run("d36", '0, 8'd36, 8'h03, 8'h00);
        run("d32", '0, 8'd32, 8'h03, 8'h00);
        run("d28", '0, 8'd28, 8'h01, 8'h00);
`endif

        // Re-pulsing start during the scan must not produce a second done.
        do_reset();
        w_tmp = 128'h9C << 24;
        @(negedge clk);
        pulse_start(w_tmp);
        repeat (4) @(negedge clk);
        pulse_start('0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (vif.done) n_done++;
            @(negedge clk);
        end
        check_eq("repulse_ndone", 32'(n_done), 32'd1);
        check_eq("repulse_level", 32'(vif.level), 32'd100);

        // Start asserted in the done cycle is accepted.
        @(negedge clk);
        pulse_start('0);
        wait_done(lat);
        check_eq("b2b_lat0", 32'(lat), 32'(c_LAT));
        check_eq("b2b_level0", 32'(vif.level), 32'd96);
        pulse_start('0);
        check_eq("b2b_busy", 32'(vif.busy), 32'd1);
        wait_done(lat);
        check_eq("b2b_lat1", 32'(lat), 32'(c_LAT));
        check_eq("b2b_level1", 32'(vif.level), 32'd92);
        check_eq("b2b_bar1", 32'(vif.bar), 32'h1F);

        // Reset during the scan aborts it and clears the level.
        @(negedge clk);
        pulse_start(128'h80);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (vif.done) n_done++;
            @(negedge clk);
        end
        check_eq("abort_ndone", 32'(n_done), 32'd0);
        check_eq("abort_level", 32'(vif.level), 32'd0);
        check_eq("abort_bar", 32'(vif.bar), 32'd0);
        check_eq("abort_busy", 32'(vif.busy), 32'd0);

`ifdef VU_PEAK_HOLD_EN
        do_reset();
        run("ph1", 128'h64 << 16, 8'd100, 8'h3F, 8'h20);
        run("ph2", '0, 8'd96, 8'h3F, 8'h20);
        run("ph3", '0, 8'd92, 8'h1F, 8'h20);
        run("ph4", '0, 8'd88, 8'h1F, 8'h10);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vu_level.md
# vu_level

Downstream consumer of the 128-bit sample window built by the 8-bit shift FIFO in the VU-meter datapath. On each `start` strobe it snapshots the window and scans the 16 signed 8-bit samples one per clock for peak magnitude. It then applies fall-off decay to a displayed level and drives an 8-segment thermometer LED bar, with an optional peak-hold marker.

## Interface
- `W`, 128: window width in bits; multiple of 8; N = W/8 samples; byte 0 (bits 7:0) is the oldest sample.
- `DECAY`, 4: amount subtracted from `level` per update when the new peak is lower.
- `HOLD`, 8: number of updates the peak marker is held (used only with `VU_PEAK_HOLD_EN`).

Ports (clock and reset first):
- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle request to process the current window.
- `window`  in  W  sample window from the FIFO `data_out`.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse when `level`/`bar`/`peak_bar` are updated.
- `level`  out  8  displayed magnitude, unsigned 0..128.
- `bar`  out  8  thermometer: `bar[k]` = (`level` >= 16*(k+1)).
- `peak_bar`  out  8  one-hot peak marker; 0 when the feature is disabled.

## Operation
- FSM states: IDLE, SCAN, UPDATE.
- IDLE:
  - `start`=1: capture `window` into an internal shift register, clear scan peak `pk_s`, zero index counter, go to SCAN.
  - `start`=0: stay in IDLE.
- SCAN: one byte per cycle, oldest first.
  - mag = |sample| as 8-bit unsigned; 0x80 (−128) yields 128 with no saturation.
  - `pk_s` = max(`pk_s`, mag).
  - After the N-th byte, go to UPDATE.
- UPDATE:
  - If `pk_s` >= `level`: `level` <= `pk_s`.
  - Otherwise: `level` <= `level` − `DECAY`, floored at 0 with no wrap.
  - Register `bar` from the new level, pulse `done`, return to IDLE.
- `start` while `busy` is ignored and not queued.
- The snapshot decouples the scan from the FIFO, so the upstream may shift during SCAN.

## Timing
- Reset (synchronous, `rst`=0 at a rising edge): state IDLE; `busy`, `done`, `level`, `bar`, `peak_bar`, `pk_s`, hold counter and peak register all 0.
- Reset mid-scan aborts the scan: no `done`, and `level` is cleared.
- `start` sampled at edge E:
  - `busy`=1 after E.
  - SCAN occupies edges E+1..E+N.
  - UPDATE completes at edge E+N+1: `done`=1, `busy`=0, outputs valid in that cycle.
  - Latency is N+1 clocks (17 at default).
- `done` is high for exactly one cycle. State is IDLE in that cycle, so `start` asserted during `done` is accepted (back-to-back rate: one window per N+1 clocks).
- Outputs change only at the UPDATE edge or on reset.

## Configuration
- `VU_PEAK_HOLD_EN` defined: adds an 8-bit peak register `pkh` and a hold counter, both updated at the UPDATE edge.
  - If `pk_s` >= `pkh`: `pkh` <= `pk_s`, counter <= `HOLD`.
  - Else if counter = 0: `pkh` <= new `level`.
  - Else: counter decrements.
  - `peak_bar` = one-hot bit (min(`pkh`/16, 8) − 1); all zeros when `pkh` < 16.
- `VU_PEAK_HOLD_EN` undefined: no hold logic; `peak_bar` is constant 0.

## Test plan
- Reset: `rst`=0 for 2 edges -> `busy`=`done`=0, `level`=0, `bar`=0x00, `peak_bar`=0x00.
- All-zero window, `start` pulse -> `done` exactly 17 edges later, `level`=0, `bar`=0x00.
- Window with byte 5 = 0x80, others 0x00 -> `level`=128, `bar`=0xFF. Byte 5 = 0x7F -> `level`=127, `bar`=0x7F.
- Byte 0 = 0xD0 (−48), then repeated all-zero windows -> `level` 48 / 44 / 40 / 36 / 32 / 28, with `bar` 0x07 / 0x03 / 0x03 / 0x03 / 0x03 / 0x01.
- `start` re-pulsed during SCAN -> ignored, single `done`. `start` in the `done` cycle -> accepted, next `done` 17 edges later. `rst`=0 at scan cycle 8 -> no `done`, `level`=0.
- With `VU_PEAK_HOLD_EN` and `HOLD`=2: peak 100, then zero windows -> `peak_bar`=0x20 for 3 updates, then follows `level` 88 -> 0x10.
